// File: rtl/eth_rmon_pkg.sv
// Shared RMON read-port constants and scheduler state encoding.
package eth_rmon_pkg;
  localparam int RMON_ADDR_W = 6;
  localparam int RMON_DATA_W = 32;
  localparam int TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RELEASE = 2'd2
  } rmon_sched_state_t;
endpackage

// File: rtl/rmon_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request above 'last', wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        found    = 1'b1;
      end
    end
    // Wrap-around pass covers requesters at or below the previous winner.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rmon_rd_sched.sv
// Round-robin scheduler for the single RMON read port; one read in flight, apply 1 cycle after request,
// response 1 cycle after grant, requests ignored while busy. RMON_RD_TIMEOUT_EN adds an APPLY watchdog.
module rmon_rd_sched
  import eth_rmon_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           aclk,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [RMON_ADDR_W*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [RMON_DATA_W-1:0]         rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [RMON_ADDR_W-1:0]         CPU_rd_addr,
  output logic                           CPU_rd_apply,
  input  logic                           CPU_rd_grant,
  input  logic [RMON_DATA_W-1:0]         CPU_rd_dout
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("rmon_rd_sched: unsupported parameter set");
  end

  rmon_sched_state_t state, state_d;

  logic [ID_W-1:0]        last, last_d;
  logic [ID_W-1:0]        cur_id, cur_id_d;
  logic [RMON_ADDR_W-1:0] addr_d;
  logic                   apply_d;
  logic [NUM_REQ-1:0]     ready_d;
  logic                   rsp_valid_d;
  logic [ID_W-1:0]        rsp_id_d;
  logic [RMON_DATA_W-1:0] rsp_data_d;
  logic                   busy_d;

  logic [NUM_REQ-1:0]     win_onehot;
  logic [ID_W-1:0]        win_idx;

`ifdef RMON_RD_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_CNT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic                 rsp_err_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (win_onehot),
    .idx   (win_idx)
  );

  always_ff @(posedge aclk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    last_d      = last;
    cur_id_d    = cur_id;
    addr_d      = CPU_rd_addr;
    apply_d     = CPU_rd_apply;
    ready_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
`ifdef RMON_RD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    rsp_err_d   = rsp_err;
`endif
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_d  = APPLY;
          last_d   = win_idx;
          cur_id_d = win_idx;
          addr_d   = req_addr[int'(win_idx)*RMON_ADDR_W +: RMON_ADDR_W];
          apply_d  = 1'b1;
          ready_d  = win_onehot;
`ifdef RMON_RD_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      APPLY: begin
        if (CPU_rd_grant) begin
          state_d     = RELEASE;
          apply_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id;
          rsp_data_d  = CPU_rd_dout;
`ifdef RMON_RD_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d     = RELEASE;
          apply_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
`endif
        end
      end
      RELEASE: begin
        // Hold off the next issue until RMON drops the previous grant.
        if (!CPU_rd_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or posedge Reset) begin
    if (Reset) begin
      last         <= ID_W'(NUM_REQ - 1);
      cur_id       <= '0;
      CPU_rd_addr  <= '0;
      CPU_rd_apply <= 1'b0;
      req_ready    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      busy         <= 1'b0;
    end else begin
      last         <= last_d;
      cur_id       <= cur_id_d;
      CPU_rd_addr  <= addr_d;
      CPU_rd_apply <= apply_d;
      req_ready    <= ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_id       <= rsp_id_d;
      rsp_data     <= rsp_data_d;
      busy         <= busy_d;
    end
  end

`ifdef RMON_RD_TIMEOUT_EN
  always_ff @(posedge aclk or posedge Reset) begin
    if (Reset) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_d;
      rsp_err <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_rmon_rd_sched.sv
// Scoreboard bench for rmon_rd_sched with a behavioural RMON read-port model.
module tb_rmon_rd_sched;
  logic        aclk;
  logic        Reset;
  logic [1:0]  req_valid;
  logic [11:0] req_addr;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [5:0]  CPU_rd_addr;
  logic        CPU_rd_apply;
  logic        CPU_rd_grant;
  logic [31:0] CPU_rd_dout;

  rmon_rd_sched #(.NUM_REQ(2), .ID_W(1), .TIMEOUT_CYCLES(16)) dut (
    .aclk         (aclk),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .CPU_rd_addr  (CPU_rd_addr),
    .CPU_rd_apply (CPU_rd_apply),
    .CPU_rd_grant (CPU_rd_grant),
    .CPU_rd_dout  (CPU_rd_dout)
  );

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] mem [64];
  int          rmon_lat  = 3;
  int          rmon_hold = 0;
  bit          rmon_en   = 1'b1;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic push_exp(input logic [0:0] id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  // RMON model: grant after rmon_lat apply cycles, held rmon_hold cycles past apply drop.
  initial begin
    int cnt;
    int hold;
    cnt = 0; hold = 0;
    CPU_rd_grant = 1'b0;
    CPU_rd_dout  = '0;
    forever begin
      @(posedge aclk); #2;
      if (Reset) begin
        CPU_rd_grant = 1'b0; cnt = 0; hold = 0;
      end else if (CPU_rd_grant) begin
        if (!CPU_rd_apply) begin
          if (hold >= rmon_hold) begin CPU_rd_grant = 1'b0; hold = 0; end
          else hold++;
        end
      end else if (CPU_rd_apply && rmon_en) begin
        if (cnt >= rmon_lat - 1) begin
          CPU_rd_grant = 1'b1; CPU_rd_dout = mem[CPU_rd_addr]; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  always @(negedge aclk) begin
    if (!Reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%0h err %0d, required no response",
                 rsp_id, rsp_data, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_any_ready(input string nm, output logic [1:0] rdy);
    rdy = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (|req_ready) begin rdy = req_ready; break; end
    end
    if (rdy == 2'b00) begin
      total++;
      $display("FAIL %s: got no req_ready in 50 cycles, required a pulse", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1 Reset = 1'b1;
    @(posedge aclk); #1 Reset = 1'b0;
  endtask

  initial begin
    logic [1:0] rdy;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'h0000_1234;
    mem[1] = 32'hAAAA_0001;
    mem[2] = 32'hBBBB_0002;
    Reset = 1'b1; req_valid = '0; req_addr = '0;
    repeat (3) @(posedge aclk);
    #1 Reset = 1'b0;

    // Reset state
    @(negedge aclk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_err, busy, CPU_rd_apply, CPU_rd_addr}, 32'd0);
    chk("reset_rsp", {rsp_data[30:0], rsp_id}, 32'd0);

    // 1: single read
    push_exp(1'b0, 32'h0000_1234, 1'b0);
    @(posedge aclk); #1 req_valid = 2'b01; req_addr = {6'h00, 6'h05};
    wait_any_ready("t1_ready", rdy);
    chk("t1_ready_vec", 32'(rdy), 32'h1);
    chk("t1_addr", 32'(CPU_rd_addr), 32'h05);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge aclk); #1 req_valid = '0;
    n = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (CPU_rd_apply) n++; else break;
    end
    chk("t1_apply_cycles", 32'(n), 32'd3);
    chk("t1_rsp_after_grant", 32'(rsp_valid), 32'd1);
    wait_idle("t1_idle");

    // 2: contention, strict alternation from reset priority
    pulse_reset();
    for (int k = 0; k < 4; k++) push_exp(1'(k % 2), (k % 2) ? mem[2] : mem[1], 1'b0);
    @(posedge aclk); #1 req_valid = 2'b11; req_addr = {6'h02, 6'h01};
    for (int k = 0; k < 4; k++) begin
      wait_any_ready("t2_ready", rdy);
      chk("t2_ready_order", 32'(rdy), (k % 2) ? 32'h2 : 32'h1);
      chk("t2_addr_order", 32'(CPU_rd_addr), (k % 2) ? 32'h02 : 32'h01);
    end
    @(posedge aclk); #1 req_valid = '0;
    wait_idle("t2_idle");

    // 3: stale grant held past apply drop
    rmon_hold = 5;
    push_exp(1'b0, mem[1], 1'b0);
    push_exp(1'b1, mem[2], 1'b0);
    @(posedge aclk); #1 req_valid = 2'b11;
    wait_any_ready("t3_ready0", rdy);
    chk("t3_first_winner", 32'(rdy), 32'h1);
    @(posedge aclk); #1 req_valid = 2'b10;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (!CPU_rd_apply) break;
    end
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      n++;
      if (req_ready[1]) break;
    end
    chk("t3_issue_delay", 32'(n), 32'd7);
    chk("t3_grant_low_at_issue", 32'(CPU_rd_grant), 32'd0);
    rmon_hold = 0;
    @(posedge aclk); #1 req_valid = '0;
    wait_idle("t3_idle");

    // 4: reset mid-APPLY, then requester 0 wins again
    rmon_lat = 10;
    @(posedge aclk); #1 req_valid = 2'b01; req_addr = {6'h02, 6'h05};
    wait_any_ready("t4_ready", rdy);
    @(posedge aclk); #1 req_valid = '0;
    @(posedge aclk); #1 Reset = 1'b1;
    #1;
    chk("t4_reset_apply_busy_rsp", {CPU_rd_apply, busy, rsp_valid}, 32'd0);
    @(posedge aclk); #1 Reset = 1'b0;
    rmon_lat = 3;
    push_exp(1'b0, mem[1], 1'b0);
    @(posedge aclk); #1 req_valid = 2'b11; req_addr = {6'h02, 6'h01};
    wait_any_ready("t4_ready_after", rdy);
    chk("t4_priority_after_reset", 32'(rdy), 32'h1);
    @(posedge aclk); #1 req_valid = '0;
    wait_idle("t4_idle");

    // 6: requester 1 pulses while busy and is never served
    push_exp(1'b0, mem[5], 1'b0);
    @(posedge aclk); #1 req_valid = 2'b01; req_addr = {6'h02, 6'h05};
    wait_any_ready("t6_ready", rdy);
    chk("t6_winner", 32'(rdy), 32'h1);
    @(posedge aclk); #1 req_valid = 2'b10;
    @(posedge aclk); #1 req_valid = 2'b00;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (req_ready[1]) n++;
    end
    chk("t6_withdrawn_grants", 32'(n), 32'd0);
    wait_idle("t6_idle");

    // 5: RMON never grants
    rmon_en = 1'b0;
`ifdef RMON_RD_TIMEOUT_EN
    push_exp(1'b0, 32'd0, 1'b1);
    @(posedge aclk); #1 req_valid = 2'b01;
    wait_any_ready("t5_ready", rdy);
    @(posedge aclk); #1 req_valid = '0;
    n = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (rsp_valid) break;
      n++;
    end
    chk("t5_timeout_cycles", 32'(n), 32'd16);
    wait_idle("t5_idle");
`else
    @(posedge aclk); #1 req_valid = 2'b01;
    wait_any_ready("t5_ready", rdy);
    @(posedge aclk); #1 req_valid = '0;
    repeat (40) @(negedge aclk);
    chk("t5_stuck_busy_apply", {busy, CPU_rd_apply}, 32'h3);
    pulse_reset();
    @(negedge aclk);
    chk("t5_busy_after_reset", 32'(busy), 32'd0);
`endif
    rmon_en = 1'b1;
    repeat (5) @(negedge aclk);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
